// File: rtl/btn_pkg.sv
// Shared types and constants for the push-button conditioner.
// Default timing assumes a 50 MHz system clock.
package btn_pkg;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      DB_PRESS   = 2'd1,
      HELD       = 2'd2,
      DB_RELEASE = 2'd3
   } btn_state_t;

   localparam int DEF_DEBOUNCE_CYCLES = 1000000;   // 20 ms
   localparam int DEF_REPEAT_DELAY    = 25000000;  // 500 ms
   localparam int DEF_REPEAT_PERIOD   = 10000000;  // 200 ms

   // Bits needed to count 0 .. n-1, never less than one.
   function automatic int cnt_width(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for asynchronous pin inputs.
// Both stages clear on the asynchronous active-low reset.
module sync_2ff #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   logic [WIDTH-1:0] r_meta;
   logic [WIDTH-1:0] r_sync;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_meta <= '0;
         r_sync <= '0;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;

endmodule

// File: rtl/button_conditioner.sv
// Synchronises and debounces a push-button, producing a clean level plus
// one-cycle press, release and auto-repeat strobes for the LED shifter.
module button_conditioner
   import btn_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
   parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
   parameter int ACTIVE_LOW      = 0
) (
   input  logic clk,
   input  logic resetn,
   input  logic i_btn,
   output logic o_level,
   output logic o_press,
   output logic o_release,
   output logic o_repeat,
   output logic o_pulse
);

   localparam int DB_W   = cnt_width(DEBOUNCE_CYCLES);
   localparam int RD_EFF = (REPEAT_DELAY > 0) ? REPEAT_DELAY : 1;
   localparam int RD_W   = cnt_width(RD_EFF);
   localparam int RP_W   = cnt_width(REPEAT_PERIOD);
   localparam int REP_W  = (RD_W > RP_W) ? RD_W : RP_W;

   localparam logic [DB_W-1:0]  DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [REP_W-1:0] RD_LAST = REP_W'(RD_EFF - 1);
   localparam logic [REP_W-1:0] RP_LAST = REP_W'(REPEAT_PERIOD - 1);
   localparam logic             REP_EN  = (REPEAT_DELAY != 0);
   localparam logic             INV     = (ACTIVE_LOW != 0);

   logic             w_sync;
   logic             w_raw;
   logic [REP_W-1:0] w_rep_last;

   btn_state_t       r_state;
   logic [DB_W-1:0]  r_db_cnt;
   logic [REP_W-1:0] r_rep_cnt;
   logic             r_rep_phase;
   logic             r_level;
   logic             r_press;
   logic             r_release;
   logic             r_repeat;
   logic             r_pulse;

   sync_2ff #(.WIDTH(1)) u_sync (
      .clk    (clk),
      .resetn (resetn),
      .i_d    (i_btn),
      .o_q    (w_sync)
   );

   // Polarity is fixed after the synchroniser so its flops clear to "not pressed" only for active-high pins.
   assign w_raw      = w_sync ^ INV;
   assign w_rep_last = r_rep_phase ? RP_LAST : RD_LAST;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state     <= IDLE;
         r_db_cnt    <= '0;
         r_rep_cnt   <= '0;
         r_rep_phase <= 1'b0;
         r_level     <= 1'b0;
         r_press     <= 1'b0;
         r_release   <= 1'b0;
         r_repeat    <= 1'b0;
         r_pulse     <= 1'b0;
      end else begin
         r_press   <= 1'b0;
         r_release <= 1'b0;
         r_repeat  <= 1'b0;
         r_pulse   <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_raw) begin
                  r_state  <= DB_PRESS;
                  r_db_cnt <= '0;
               end
            end
            DB_PRESS: begin
               if (!w_raw) begin
                  r_state <= IDLE;
               end else if (r_db_cnt == DB_LAST) begin
                  r_state     <= HELD;
                  r_press     <= 1'b1;
                  r_pulse     <= 1'b1;
                  r_level     <= 1'b1;
                  r_rep_cnt   <= '0;
                  r_rep_phase <= 1'b0;
               end else begin
                  r_db_cnt <= r_db_cnt + 1'b1;
               end
            end
            HELD: begin
               if (!w_raw) begin
                  r_state     <= DB_RELEASE;
                  r_db_cnt    <= '0;
                  r_rep_cnt   <= '0;
                  r_rep_phase <= 1'b0;
               end else if (REP_EN) begin
                  // Phase 0 waits out the initial delay, phase 1 the repeat period.
                  if (r_rep_cnt == w_rep_last) begin
                     r_repeat    <= 1'b1;
                     r_pulse     <= 1'b1;
                     r_rep_cnt   <= '0;
                     r_rep_phase <= 1'b1;
                  end else if (r_rep_cnt != '1) begin
                     r_rep_cnt <= r_rep_cnt + 1'b1;
                  end
               end
            end
            DB_RELEASE: begin
               if (w_raw) begin
                  r_state     <= HELD;
                  r_rep_cnt   <= '0;
                  r_rep_phase <= 1'b0;
               end else if (r_db_cnt == DB_LAST) begin
                  r_state   <= IDLE;
                  r_release <= 1'b1;
                  r_level   <= 1'b0;
               end else begin
                  r_db_cnt <= r_db_cnt + 1'b1;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign o_level   = r_level;
   assign o_press   = r_press;
   assign o_release = r_release;
   assign o_repeat  = r_repeat;
   assign o_pulse   = r_pulse;

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: an active-high and an active-low instance
// checked every cycle against a run-length model of the debounce/repeat rules.
module tb_button_conditioner;

   localparam int DB = 4;
   localparam int RD = 8;
   localparam int RP = 3;

   logic       clk;
   logic       resetn;
   logic [1:0] btn;
   logic [1:0] lvl, prs, rel, rpt, pls;

   int n_checks = 0;
   int n_fail   = 0;
   int edge_n   = 0;

   // Model state: 2-stage input history, accepted level, disagreeing-run and hold-age lengths.
   logic m_p1[2], m_p2[2], m_prev[2], m_level[2];
   int   m_run[2], m_age[2];
   logic e_press[2], e_rel[2], e_rep[2];

   // Observed event log per scenario.
   int first_press[2], last_press[2], n_press[2];
   int first_rep[2], n_rep[2];
   int last_rel[2], n_rel[2], n_lvl_hi[2];
   logic [31:0] rep_q[$];
   logic [31:0] exp_q[$];

   button_conditioner #(.DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .ACTIVE_LOW(0)) u_dut_hi (
      .clk(clk), .resetn(resetn), .i_btn(btn[0]), .o_level(lvl[0]), .o_press(prs[0]),
      .o_release(rel[0]), .o_repeat(rpt[0]), .o_pulse(pls[0])
   );

   button_conditioner #(.DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .ACTIVE_LOW(1)) u_dut_lo (
      .clk(clk), .resetn(resetn), .i_btn(btn[1]), .o_level(lvl[1]), .o_press(prs[1]),
      .o_release(rel[1]), .o_repeat(rpt[1]), .o_pulse(pls[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0d exp=%0d (edge %0d)", tag, got, exp, edge_n);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_p1[k] = 1'b0; m_p2[k] = 1'b0; m_prev[k] = 1'b0; m_level[k] = 1'b0;
         m_run[k] = 0; m_age[k] = 0;
         e_press[k] = 1'b0; e_rel[k] = 1'b0; e_rep[k] = 1'b0;
      end
   endtask

   // A change is accepted once the synchronised input has disagreed with the
   // level for DB+1 consecutive edges; repeats count edges spent held steadily.
   task automatic model_edge(input int k, input logic b);
      logic raw;
      raw = m_p2[k] ^ (k == 1);
      e_press[k] = 1'b0; e_rel[k] = 1'b0; e_rep[k] = 1'b0;
      if (m_level[k]) begin
         if (raw && m_prev[k]) begin
            m_age[k]++;
            if (RD != 0 && m_age[k] >= RD && (m_age[k] - RD) % RP == 0) e_rep[k] = 1'b1;
         end else begin
            m_age[k] = 0;
         end
      end
      if (raw != m_level[k]) m_run[k]++;
      else m_run[k] = 0;
      if (m_run[k] == DB + 1) begin
         m_level[k] = ~m_level[k];
         m_run[k]   = 0;
         m_age[k]   = 0;
         if (m_level[k]) e_press[k] = 1'b1;
         else e_rel[k] = 1'b1;
      end
      m_prev[k] = raw;
      m_p2[k]   = m_p1[k];
      m_p1[k]   = b;
   endtask

   task automatic compare_all(input string pfx);
      for (int k = 0; k < 2; k++) begin
         check_val($sformatf("%s_level%0d", pfx, k),   lvl[k], m_level[k]);
         check_val($sformatf("%s_press%0d", pfx, k),   prs[k], e_press[k]);
         check_val($sformatf("%s_release%0d", pfx, k), rel[k], e_rel[k]);
         check_val($sformatf("%s_repeat%0d", pfx, k),  rpt[k], e_rep[k]);
         check_val($sformatf("%s_pulse%0d", pfx, k),   pls[k], e_press[k] | e_rep[k]);
      end
   endtask

   task automatic scen_start();
      edge_n = 0;
      rep_q.delete();
      for (int k = 0; k < 2; k++) begin
         first_press[k] = -1; last_press[k] = -1; n_press[k] = 0;
         first_rep[k] = -1; n_rep[k] = 0;
         last_rel[k] = -1; n_rel[k] = 0; n_lvl_hi[k] = 0;
      end
   endtask

   // Called just after a negedge: drive, let one rising edge happen, check at the next negedge.
   task automatic step(input logic [1:0] b);
      btn = b;
      @(posedge clk);
      if (resetn) begin
         for (int k = 0; k < 2; k++) model_edge(k, b[k]);
      end else begin
         model_reset();
      end
      @(negedge clk);
      compare_all("cyc");
      for (int k = 0; k < 2; k++) begin
         if (prs[k]) begin
            n_press[k]++;
            if (first_press[k] < 0) first_press[k] = edge_n;
            last_press[k] = edge_n;
         end
         if (rpt[k]) begin
            n_rep[k]++;
            if (first_rep[k] < 0) first_rep[k] = edge_n;
            if (k == 0) rep_q.push_back(32'(edge_n));
         end
         if (rel[k]) begin
            n_rel[k]++;
            last_rel[k] = edge_n;
         end
         if (lvl[k]) n_lvl_hi[k]++;
      end
      edge_n++;
   endtask

   // Logical press p: instance 0 sees p, the active-low instance sees ~p.
   task automatic press_steps(input logic p, input int n);
      for (int i = 0; i < n; i++) step({~p, p});
   endtask

   task automatic assert_reset();
      resetn = 1'b0;
      model_reset();
      #1;
      compare_all("rst");
   endtask

   initial begin
      resetn = 1'b0;
      btn    = 2'b10;
      model_reset();
      scen_start();
      #1;
      compare_all("rst0");
      @(negedge clk);
      press_steps(1'b0, 3);
      resetn = 1'b1;
      press_steps(1'b0, 10);

      // Clean press held long enough for four auto-repeats (edges 0..23).
      scen_start();
      press_steps(1'b1, 24);
      exp_q = '{32'd14, 32'd17, 32'd20, 32'd23};
      for (int k = 0; k < 2; k++) begin
         check_val($sformatf("press_edge%0d", k), first_press[k], 6);
         check_val($sformatf("press_count%0d", k), n_press[k], 1);
         check_val($sformatf("first_repeat%0d", k), first_rep[k], 14);
         check_val($sformatf("repeat_count%0d", k), n_rep[k], 4);
         check_val($sformatf("held_level%0d", k), lvl[k], 1);
      end
      check_val("repeat_q_size", rep_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < rep_q.size(); i++)
         check_val($sformatf("repeat_q%0d", i), rep_q[i], exp_q[i]);

      // Release with bounce: low 2, high 1, then low steady from edge 3.
      scen_start();
      press_steps(1'b0, 2);
      press_steps(1'b1, 1);
      press_steps(1'b0, 12);
      for (int k = 0; k < 2; k++) begin
         check_val($sformatf("bounce_press%0d", k), n_press[k], 0);
         check_val($sformatf("bounce_repeat%0d", k), n_rep[k], 0);
         check_val($sformatf("release_count%0d", k), n_rel[k], 1);
         check_val($sformatf("release_edge%0d", k), last_rel[k], 3 + 6);
         check_val($sformatf("released_level%0d", k), lvl[k], 0);
      end

      // Glitch: three edges high, then low.
      press_steps(1'b0, 6);
      scen_start();
      press_steps(1'b1, 3);
      press_steps(1'b0, 10);
      for (int k = 0; k < 2; k++) begin
         check_val($sformatf("glitch_press%0d", k), n_press[k], 0);
         check_val($sformatf("glitch_level_cycles%0d", k), n_lvl_hi[k], 0);
      end

      // Reset mid-hold at edge 16, released before edge 20, button still held.
      scen_start();
      press_steps(1'b1, 16);
      assert_reset();
      press_steps(1'b1, 4);
      resetn = 1'b1;
      press_steps(1'b1, 10);
      for (int k = 0; k < 2; k++) begin
         check_val($sformatf("rst_press_count%0d", k), n_press[k], 2);
         // Active-low instance: cleared synchroniser already reads "pressed", so two edges sooner.
         check_val($sformatf("rst_press_edge%0d", k), last_press[k], (k == 0) ? 26 : 24);
      end
      press_steps(1'b0, 12);

      // Random stimulus, independent per instance, with occasional resets.
      for (int s = 0; s < 300; s++) begin
         logic [1:0] b;
         int dur;
         b   = 2'($urandom_range(0, 3));
         dur = $urandom_range(1, 14);
         if ($urandom_range(0, 24) == 0) begin
            assert_reset();
            for (int i = 0; i < int'($urandom_range(1, 3)); i++) step(b);
            resetn = 1'b1;
         end
         for (int i = 0; i < dur; i++) step(b);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
